// File: rtl/sseg_scan_driver.sv
// Time-multiplexed 4-digit common-anode seven-segment driver.
// Inputs are latched once per frame into shadow registers; every output is registered.
module sseg_scan_driver #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] value,
    input  logic [3:0]  digit_en,
    input  logic        lz_suppress,
    output logic [6:0]  segments,
    output logic [3:0]  anodes,
    output logic        frame_start
);

    localparam int TW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST  = TW'(REFRESH_DIV - 1);
    localparam logic [TW-1:0] TICK_BLANK = TW'(BLANK_CYCLES);

    logic [TW-1:0] tick_cnt;
    logic [1:0]    digit_idx;
    logic          first_load;
    logic [15:0]   sh_val;
    logic [3:0]    sh_en;
    logic          sh_lz;

    logic          tick_wrap;
    logic          load;
    logic [3:0]    upper_zero;
    logic [3:0]    nib;
    logic          dark;
    logic [6:0]    seg_nxt;
    logic [3:0]    an_nxt;

    function automatic logic [6:0] enc(input logic [3:0] n);
        case (n)
            4'h0: enc = 7'b0000001;
            4'h1: enc = 7'b1001111;
            4'h2: enc = 7'b0010010;
            4'h3: enc = 7'b0000110;
            4'h4: enc = 7'b1001100;
            4'h5: enc = 7'b0100100;
            4'h6: enc = 7'b0100000;
            4'h7: enc = 7'b0001111;
            4'h8: enc = 7'b0000000;
            4'h9: enc = 7'b0000100;
            4'hA: enc = 7'b0001000;
            4'hB: enc = 7'b1100000;
            4'hC: enc = 7'b0110001;
            4'hD: enc = 7'b1000010;
            4'hE: enc = 7'b0110000;
            default: enc = 7'b0111000;
        endcase
    endfunction

    assign tick_wrap = (tick_cnt == TICK_LAST);
    // Load on entry to digit 0 of each frame, plus once right after reset.
    assign load      = first_load | (tick_wrap & (digit_idx == 2'd3));

    // upper_zero[g]: nibbles g..3 of the shadow value are all zero.
    for (genvar g = 0; g < 4; g++) begin : g_uz
        assign upper_zero[g] = (sh_val[15:4*g] == '0);
    end

    assign nib  = sh_val[digit_idx*4 +: 4];
    assign dark = ~sh_en[digit_idx] | (sh_lz & (digit_idx != 2'd0) & upper_zero[digit_idx]);

    always_comb begin
        seg_nxt = 7'b1111111;
        an_nxt  = 4'b1111;
        if (tick_cnt >= TICK_BLANK && !dark) begin
            seg_nxt = enc(nib);
            an_nxt  = ~(4'b0001 << digit_idx);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tick_cnt    <= '0;
            digit_idx   <= 2'd0;
            first_load  <= 1'b1;
            sh_val      <= 16'h0000;
            sh_en       <= 4'b0000;
            sh_lz       <= 1'b0;
            segments    <= 7'b1111111;
            anodes      <= 4'b1111;
            frame_start <= 1'b0;
        end else begin
            tick_cnt <= tick_wrap ? '0 : tick_cnt + 1'b1;
            if (tick_wrap)
                digit_idx <= digit_idx + 2'd1;
            if (load) begin
                first_load <= 1'b0;
                sh_val     <= value;
                sh_en      <= digit_en;
                sh_lz      <= lz_suppress;
            end
            segments    <= seg_nxt;
            anodes      <= an_nxt;
            frame_start <= load;
        end
    end

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Self-checking bench for sseg_scan_driver: per-cycle scoreboard of expected outputs
// from a frame/slot reference model, plus scenario checks and a decoder model.
module tb_sseg_scan_driver;

    localparam int DIV = 8;
    localparam int BLK = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] value = 16'hFFFF;
    logic [3:0]  digit_en = 4'hF;
    logic        lz_suppress = 1'b0;
    logic [6:0]  segments;
    logic [3:0]  anodes;
    logic        frame_start;

    sseg_scan_driver #(.REFRESH_DIV(DIV), .BLANK_CYCLES(BLK)) dut (
        .clk(clk), .rst_n(rst_n), .value(value), .digit_en(digit_en),
        .lz_suppress(lz_suppress), .segments(segments), .anodes(anodes),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       fs;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_err = 0;

    logic [6:0] enc_tab [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    // reference model state (what the DUT holds after the last edge)
    int          m_tick = 0;
    int          m_idx = 0;
    bit          m_first = 1'b1;
    logic [15:0] m_val = '0;
    logic [3:0]  m_en = '0;
    bit          m_lz = 1'b0;

    // observation accumulators
    int          fs_cnt = 0;
    int          off_digit0_lit = 0;
    int          bad_mask_lit = 0;
    logic [15:0] dec_val = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_step(output exp_t e);
        bit load, dk;
        logic [3:0] n;
        e = '{an: 4'hF, seg: 7'h7F, fs: 1'b0};
        if (!rst_n) begin
            m_tick = 0; m_idx = 0; m_first = 1'b1;
            m_val = '0; m_en = '0; m_lz = 1'b0;
            return;
        end
        load = m_first || (m_tick == DIV-1 && m_idx == 3);
        e.fs = load;
        if (m_tick >= BLK) begin
            n  = m_val[m_idx*4 +: 4];
            dk = !m_en[m_idx] || (m_lz && m_idx >= 1 && (m_val >> (4*m_idx)) == 16'h0);
            if (!dk) begin
                e.an  = 4'hF;
                e.an[m_idx] = 1'b0;
                e.seg = enc_tab[n];
            end
        end
        if (load) begin
            m_val = value; m_en = digit_en; m_lz = lz_suppress; m_first = 1'b0;
        end
        if (m_tick == DIV-1) begin
            m_tick = 0;
            m_idx  = (m_idx + 1) % 4;
        end else begin
            m_tick++;
        end
    endtask

    task automatic cycle();
        exp_t e, got;
        model_step(e);
        q.push_back(e);
        @(posedge clk);
        #1;
        got = q.pop_front();
        chk("anodes", anodes, got.an);
        chk("segments", segments, got.seg);
        chk("frame_start", frame_start, got.fs);
        chk("one_anode", ($countones(~anodes) <= 1), 1);
        if (frame_start) fs_cnt++;
        if (anodes != 4'hF && anodes != 4'b1110) off_digit0_lit++;
        if (anodes != 4'hF && anodes != 4'b1110 && anodes != 4'b1011) bad_mask_lit++;
        // downstream decoder: recover the nibble of whichever digit is lit
        for (int d = 0; d < 4; d++)
            if (anodes == ~(4'b0001 << d))
                for (int k = 0; k < 16; k++)
                    if (enc_tab[k] == segments) dec_val[d*4 +: 4] = 4'(k);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // advance until the DUT is at (idx, tick); bounded by two frames
    task automatic seek(input string tag, input int idx, input int tick);
        int i;
        for (i = 0; i < 8*DIV && !(m_idx == idx && m_tick == tick); i++) cycle();
        chk(tag, (m_idx == idx && m_tick == tick), 1);
    endtask

    initial begin
        // reset held with all-ones input
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("rst_outputs", {anodes, segments, frame_start}, {4'hF, 7'h7F, 1'b0});
        end

        // basic scan of 1234
        value = 16'h1234; digit_en = 4'hF; lz_suppress = 1'b0;
        rst_n = 1'b1;
        fs_cnt = 0;
        run(2);
        chk("fs_after_rst", (fs_cnt == 1), 1);
        run(4*DIV - 2);
        fs_cnt = 0; dec_val = '0;
        run(8*DIV);
        chk("fs_per_frame", fs_cnt, 2);
        chk("decode_1234", dec_val, 16'h1234);

        // change value mid-frame, during digit 2
        seek("seek_d2", 2, 3);
        value = 16'hABCD;
        seek("seek_d3", 3, BLK + 1);
        cycle();
        chk("no_tear_d3", {anodes, segments}, {4'b0111, 7'b1001111});
        dec_val = '0;
        seek("seek_frame", 0, 1);
        run(4*DIV);
        chk("decode_abcd", dec_val, 16'hABCD);

        // leading-zero suppression
        value = 16'h0070; lz_suppress = 1'b1;
        run(8*DIV);
        seek("seek_lz", 1, BLK + 1);
        cycle();
        chk("lz_d1", {anodes, segments}, {4'b1101, 7'b0001111});
        value = 16'h0000;
        run(4*DIV);
        off_digit0_lit = 0;
        run(8*DIV);
        chk("lz_zero_only_d0", off_digit0_lit, 0);

        // enable mask
        value = 16'h8888; digit_en = 4'b0101; lz_suppress = 1'b0;
        run(4*DIV);
        bad_mask_lit = 0;
        run(8*DIV);
        chk("mask_only_0_2", bad_mask_lit, 0);

        // reset pulse while digit 2 lit
        digit_en = 4'hF; value = 16'h1234;
        run(4*DIV);
        seek("seek_rst", 2, BLK + 3);
        chk("d2_lit_before_rst", anodes, 4'b1011);
        rst_n = 1'b0;
        cycle();
        chk("rst_mid_slot", {anodes, segments}, {4'hF, 7'h7F});
        rst_n = 1'b1;
        fs_cnt = 0;
        run(2);
        chk("fs_after_rst2", fs_cnt, 1);
        dec_val = '0;
        run(4*DIV);
        chk("decode_after_rst", dec_val, 16'h1234);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/sseg_scan_driver.md
Name: sseg_scan_driver

Overview:
- Time-multiplexed driver for a 4-digit, common-anode seven-segment display; upstream stage of the on-board display path.
- Converts a 16-bit hex value into active-low `segments` and `anodes` scan outputs.
- Its outputs are exactly the encoding the team's segment-decoding checker consumes.
- Includes a refresh counter, frame-synchronous value latching, per-digit enable, leading-zero suppression, and anti-ghosting blanking.

Parameters:
- REFRESH_DIV, 100000: clock cycles per digit slot; legal range 4..2^20.
- BLANK_CYCLES, 4: cycles at the start of each slot with all anodes off; must be less than REFRESH_DIV.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset.
- value  input  16  hex value to display; nibble i drives digit i (digit 0 is rightmost).
- digit_en  input  4  per-digit enable; 0 forces that digit dark.
- lz_suppress  input  1  1 = blank leading zero digits.
- segments  output  7  {a,b,c,d,e,f,g}, active-low (0 = segment lit).
- anodes  output  4  active-low digit select; at most one bit is 0 at any time.
- frame_start  output  1  one-cycle pulse when a new value is latched.

Interface decision: one clock; reset is synchronous and active-low.

Behaviour:
- Reset (rst_n=0 at a clk edge) sets:
  - tick_cnt=0, digit_idx=0
  - shadow value=16'h0000, shadow enable=4'b0000, shadow lz=0
  - segments=7'b1111111, anodes=4'b1111, frame_start=0
- Reset asserted mid-scan aborts the slot immediately; the outputs above are visible the cycle after the reset edge.
- Counters:
  - tick_cnt counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, digit_idx increments mod 4 (order 0,1,2,3,0,...).
  - One frame = 4*REFRESH_DIV cycles.
- Shadow load:
  - value, digit_en and lz_suppress are copied into shadow registers on the edge where tick_cnt=REFRESH_DIV-1 and digit_idx=3 (entering digit 0 of a new frame).
  - The first load also occurs on the first edge after reset release (tick_cnt=0, digit_idx=0, flagged by a post-reset bit).
  - frame_start=1 in the cycle after each load, otherwise 0.
  - Input changes mid-frame are not visible until the next frame, so there is no tearing.
- Output stage is fully registered: segments, anodes and frame_start are computed from current tick_cnt/digit_idx/shadow state and appear one clock later.
- Blanking: when tick_cnt < BLANK_CYCLES, the next outputs are anodes=4'b1111 and segments=7'b1111111.
- Active portion of a slot, for digit d=digit_idx and n=shadow nibble d:
  - Digit d is dark if shadow_en[d]=0, or if shadow_lz=1, d≥1, and nibbles d..3 are all zero. Digit 0 is never zero-suppressed.
  - Dark: anodes=4'b1111, segments=7'b1111111.
  - Lit: anodes = all ones except bit d = 0; segments = encode(n).
- Encoding, fixed and bit-exact:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, B=1100000
  - C=0110001, D=1000010, E=0110000, F=0111000
- No output ever has more than one anode low, including during the digit-transition cycle (guaranteed by BLANK_CYCLES≥1; with BLANK_CYCLES=0, switching is still single-cycle with no overlap because outputs are registered).
- Counter widths are $clog2(REFRESH_DIV); no overflow beyond the wrap.

Test Plan:
- Reset check:
  - Stimulus: hold rst_n=0 for 5 cycles with value=16'hFFFF.
  - Required: segments=7'b1111111, anodes=4'b1111, frame_start=0 throughout.
  - After release: frame_start pulses within 2 cycles.
- Basic scan:
  - Stimulus: REFRESH_DIV=8, BLANK_CYCLES=2, value=16'h1234, digit_en=4'hF, lz_suppress=0.
  - Required per slot: 2 blank cycles, then 6 cycles of:
    - anodes=1110, segments=1001100 (4)
    - anodes=1101, segments=0000110 (3)
    - anodes=1011, segments=0010010 (2)
    - anodes=0111, segments=1001111 (1)
  - A downstream decoder model reconstructs 16'h1234.
- Frame latching:
  - Stimulus: change value from 16'h1234 to 16'hABCD during digit 2's slot.
  - Required: digit 3 still shows 1 (1001111); the next frame shows D,C,B,A; frame_start pulses exactly once per 32 cycles.
- Leading-zero suppression:
  - Stimulus: value=16'h0070, lz_suppress=1.
  - Required: digits 3 and 2 keep anodes=1111 for their whole slots; digit 1 shows 0001111 and digit 0 shows 0000001.
  - With value=16'h0000: only digit 0 lights, showing 0000001.
- Enable mask:
  - Stimulus: digit_en=4'b0101, value=16'h8888.
  - Required: only anodes=1110 and 1011 ever assert, each with segments=0000000; slots 1 and 3 stay fully dark.
- Reset mid-slot:
  - Stimulus: pulse rst_n=0 for 1 cycle while digit 2 is lit.
  - Required: the next cycle shows anodes=1111 and segments=1111111.
  - Scan restarts at digit 0 with a fresh shadow load; the single-anode invariant holds on every cycle of every test.
